// File: rtl/kbd_receiver_pkg.sv
// Shared constants for the KL8E keyboard receiver: major-state encodings,
// IOT opcode and function codes, and the receive FSM state type.
package kbd_receiver_pkg;

   localparam logic [3:0] F0 = 4'b0001;
   localparam logic [3:0] F1 = 4'b0010;
   localparam logic [3:0] F2 = 4'b0100;
   localparam logic [3:0] F3 = 4'b1000;

   localparam logic [2:0] IOT_OP = 3'o6;

   localparam logic [2:0] KCF = 3'o0;
   localparam logic [2:0] KSF = 3'o1;
   localparam logic [2:0] KCC = 3'o2;
   localparam logic [2:0] KRS = 3'o4;
   localparam logic [2:0] KIE = 3'o5;
   localparam logic [2:0] KRB = 3'o6;

   localparam int         DEFAULT_CLKS_PER_BIT = 32;
   localparam logic [5:0] DEFAULT_DEV_ID       = 6'o03;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_FRAME_ERR
   } rx_state_t;

   function automatic logic is_iot(input logic [0:11] instr, input logic [5:0] dev);
      return (instr[0:2] == IOT_OP) && (instr[3:8] == dev);
   endfunction

endpackage

// File: rtl/kbd_receiver_uart_rx_core.sv
// 8N1 asynchronous receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-cycle char_valid strobe coincident with a good stop-bit sample.
//
//   state        | meaning
//   RX_IDLE      | line idle, waiting for rx_s low
//   RX_START     | half-bit wait, confirm start bit still low
//   RX_DATA      | sampling 8 data bits LSB first at mid-bit
//   RX_STOP      | sampling stop bit; high completes the character
//   RX_FRAME_ERR | stop bit was low; wait for line to return high
module uart_rx_core
   import kbd_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] char,
   output logic       char_valid
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   rx_state_t      rx_state, state_next;
   logic           sync_1, rx_s;
   logic [CW-1:0]  bit_cnt, cnt_next;
   logic [2:0]     bit_idx, idx_next;
   logic [7:0]     shift, shift_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1   <= 1'b1;
         rx_s     <= 1'b1;
         rx_state <= RX_IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         sync_1   <= rx;
         rx_s     <= sync_1;
         rx_state <= state_next;
         bit_cnt  <= cnt_next;
         bit_idx  <= idx_next;
         shift    <= shift_next;
      end
   end

   always_comb begin
      state_next = rx_state;
      cnt_next   = bit_cnt;
      idx_next   = bit_idx;
      shift_next = shift;
      char_valid = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               cnt_next   = HALF_LOAD;
               state_next = RX_START;
            end
         end
         RX_START: begin
            if (bit_cnt != '0) begin
               cnt_next = bit_cnt - 1'b1;
            end else if (rx_s) begin
               state_next = RX_IDLE;
            end else begin
               cnt_next   = FULL_LOAD;
               idx_next   = 3'd0;
               state_next = RX_DATA;
            end
         end
         RX_DATA: begin
            if (bit_cnt != '0) begin
               cnt_next = bit_cnt - 1'b1;
            end else begin
               shift_next[bit_idx] = rx_s;
               cnt_next            = FULL_LOAD;
               if (bit_idx == 3'd7) begin
                  state_next = RX_STOP;
               end else begin
                  idx_next = bit_idx + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (bit_cnt != '0) begin
               cnt_next = bit_cnt - 1'b1;
            end else if (rx_s) begin
               char_valid = 1'b1;
               state_next = RX_IDLE;
            end else begin
               state_next = RX_FRAME_ERR;
            end
         end
         RX_FRAME_ERR: begin
            if (rx_s) begin
               state_next = RX_IDLE;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   // shift is complete once bit 7 is taken, so it is the character at the stop sample
   assign char = shift;

endmodule

// File: rtl/kbd_receiver.sv
// KL8E keyboard: wraps the serial receiver with the keyboard flag,
// interrupt enable and device IOT decode for the CPU.
module kbd_receiver
   import kbd_receiver_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter logic [5:0] DEV_ID       = DEFAULT_DEV_ID
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:11] instruction,
   input  logic [3:0]  state,
   input  logic [0:11] ac,
   input  logic        rx,
   output logic [0:11] serial_bus,
   output logic        clear_ac,
   output logic        skip,
   output logic        interrupt
);

   logic [7:0] rx_char;
   logic       char_valid;
   logic [7:0] rx_buffer;
   logic       flag;
   logic       int_enable;
   logic       iot_f1;
   logic [2:0] fn;
   logic       unused_ac;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_core (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .char      (rx_char),
      .char_valid(char_valid)
   );

   assign fn        = instruction[9:11];
   assign iot_f1    = (state == F1) && is_iot(instruction, DEV_ID);
   assign unused_ac = &{1'b0, ac[0:10]};

   // A completing character beats any flag-clearing IOT on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_buffer  <= 8'h00;
         flag       <= 1'b0;
         int_enable <= 1'b1;
      end else begin
         if (char_valid) begin
            rx_buffer <= rx_char;
            flag      <= 1'b1;
         end else if (iot_f1 && (fn == KCF || fn == KCC || fn == KRB)) begin
            flag <= 1'b0;
         end
         if (iot_f1 && fn == KIE) begin
            int_enable <= ac[11];
         end
      end
   end

   always_comb begin
      serial_bus = 12'o0000;
      clear_ac   = 1'b0;
      skip       = 1'b0;
      if (iot_f1) begin
         case (fn)
            KSF: skip = flag;
            KCC: clear_ac = 1'b1;
            KRS: serial_bus = {4'b0000, rx_buffer};
            KRB: begin
               clear_ac   = 1'b1;
               serial_bus = {4'b0000, rx_buffer};
            end
            default: ;
         endcase
      end
   end

   assign interrupt = flag & int_enable;

endmodule

// File: tb/tb_kbd_receiver.sv
// Directed bench for kbd_receiver: IOT decode table plus hand-written
// serial sequences for timing, glitch, framing, collision and reset cases.
module tb_kbd_receiver;
   import kbd_receiver_pkg::*;

   localparam int CPB = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [0:11] instruction;
   logic [3:0]  state;
   logic [0:11] ac;
   logic [0:11] serial_bus;
   logic        clear_ac;
   logic        skip;
   logic        interrupt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   kbd_receiver #(
      .CLKS_PER_BIT(CPB),
      .DEV_ID      (6'o03)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .instruction(instruction),
      .state      (state),
      .ac         (ac),
      .rx         (rx),
      .serial_bus (serial_bus),
      .clear_ac   (clear_ac),
      .skip       (skip),
      .interrupt  (interrupt)
   );

   typedef struct {
      logic [11:0] instr;
      logic [3:0]  st;
      logic        exp_skip;
      logic        exp_clr;
      logic [11:0] exp_bus;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %o, expected %o", name, act, exp);
      end
   endtask

   // Called at a falling edge; each bit is held for CPB clocks
   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   // One F1 cycle: combinational outputs sampled before the edge, interrupt after it
   task automatic iot_chk(input string name, input logic [11:0] instr, input logic [3:0] st,
                          input logic [11:0] acv, input logic exp_s, input logic exp_c,
                          input logic [11:0] exp_b, input logic exp_irq);
      logic s, c, irq;
      logic [11:0] b;
      instruction = instr;
      state       = st;
      ac          = acv;
      #1;
      s = skip;
      c = clear_ac;
      b = serial_bus;
      @(negedge clk);
      state       = F0;
      instruction = 12'o0000;
      ac          = 12'o0000;
      #1;
      irq = interrupt;
      chk({name, ".skip"}, {11'b0, s}, {11'b0, exp_s});
      chk({name, ".clear_ac"}, {11'b0, c}, {11'b0, exp_c});
      chk({name, ".serial_bus"}, b, exp_b);
      chk({name, ".interrupt"}, {11'b0, irq}, {11'b0, exp_irq});
   endtask

   initial begin
      vecs[0]  = '{12'o6031, F1, 1'b1, 1'b0, 12'o0000, 1'b1};
      vecs[1]  = '{12'o6031, F0, 1'b0, 1'b0, 12'o0000, 1'b1};
      vecs[2]  = '{12'o6041, F1, 1'b0, 1'b0, 12'o0000, 1'b1};
      vecs[3]  = '{12'o6033, F1, 1'b0, 1'b0, 12'o0000, 1'b1};
      vecs[4]  = '{12'o6034, F1, 1'b0, 1'b0, 12'o0125, 1'b1};
      vecs[5]  = '{12'o6037, F1, 1'b0, 1'b0, 12'o0000, 1'b1};
      vecs[6]  = '{12'o6036, F2, 1'b0, 1'b0, 12'o0000, 1'b1};
      vecs[7]  = '{12'o6036, F1, 1'b0, 1'b1, 12'o0125, 1'b0};
      vecs[8]  = '{12'o6031, F1, 1'b0, 1'b0, 12'o0000, 1'b0};
      vecs[9]  = '{12'o6034, F1, 1'b0, 1'b0, 12'o0125, 1'b0};
      vecs[10] = '{12'o6032, F1, 1'b0, 1'b1, 12'o0000, 1'b0};

      reset       = 1'b1;
      rx          = 1'b1;
      instruction = 12'o6034;
      state       = F1;
      ac          = 12'o0000;
      repeat (3) @(negedge clk);
      #1;
      chk("reset.serial_bus", serial_bus, 12'o0000);
      chk("reset.interrupt", {11'b0, interrupt}, 12'o0000);
      state       = F0;
      instruction = 12'o0000;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset.clear_ac", {11'b0, clear_ac}, 12'o0000);
      chk("reset.skip", {11'b0, skip}, 12'o0000);
      @(negedge clk);
      iot_chk("reset.ksf", 12'o6031, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);

      // 0x55: flag must rise on the stop sample, 307 clocks after the start edge
      @(negedge clk);
      fork
         send_byte(8'h55, 1'b1);
         begin
            repeat (306) @(negedge clk);
            #1 chk("t1.before_stop", {11'b0, interrupt}, 12'o0000);
            @(negedge clk);
            #1 chk("t1.at_stop", {11'b0, interrupt}, 12'o0001);
         end
      join
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         iot_chk($sformatf("t2.vec%0d", i), vecs[i].instr, vecs[i].st, 12'o0000,
                 vecs[i].exp_skip, vecs[i].exp_clr, vecs[i].exp_bus, vecs[i].exp_irq);
      end

      // Interrupt enable off, then on
      iot_chk("t3.kie0", 12'o6035, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);
      @(negedge clk);
      send_byte(8'hA3, 1'b1);
      repeat (4) @(negedge clk);
      iot_chk("t3.ksf", 12'o6031, F1, 12'o0000, 1'b1, 1'b0, 12'o0000, 1'b0);
      iot_chk("t3.krs", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0243, 1'b0);
      iot_chk("t3.kie1", 12'o6035, F1, 12'o0001, 1'b0, 1'b0, 12'o0000, 1'b1);
      iot_chk("t3.kcf", 12'o6030, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);

      // 8-clock glitch, then a framing error
      @(negedge clk);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      iot_chk("t4.glitch_ksf", 12'o6031, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);
      iot_chk("t4.glitch_krs", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0243, 1'b0);
      @(negedge clk);
      send_byte(8'h5A, 1'b0);
      repeat (10) @(negedge clk);
      iot_chk("t4.frame_ksf", 12'o6031, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);
      iot_chk("t4.frame_krs", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0243, 1'b0);

      // KCF on the same edge as the stop sample of 0x41
      @(negedge clk);
      fork
         send_byte(8'h41, 1'b1);
         begin
            repeat (306) @(negedge clk);
            instruction = 12'o6030;
            state       = F1;
            @(negedge clk);
            state       = F0;
            instruction = 12'o0000;
            #1 chk("t5.set_wins", {11'b0, interrupt}, 12'o0001);
         end
      join
      @(negedge clk);
      iot_chk("t5.ksf", 12'o6031, F1, 12'o0000, 1'b1, 1'b0, 12'o0000, 1'b1);
      iot_chk("t5.krs", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0101, 1'b1);

      // Reset in the middle of the data bits
      iot_chk("t6.kie0", 12'o6035, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB * 3) @(negedge clk);
      reset       = 1'b1;
      rx          = 1'b1;
      instruction = 12'o6034;
      state       = F1;
      #1;
      chk("t6.reset_bus", serial_bus, 12'o0000);
      chk("t6.reset_irq", {11'b0, interrupt}, 12'o0000);
      @(negedge clk);
      reset       = 1'b0;
      state       = F0;
      instruction = 12'o0000;
      @(negedge clk);
      iot_chk("t6.ksf", 12'o6031, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);
      iot_chk("t6.krs", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0);
      repeat (400) @(negedge clk);
      #1 chk("t6.no_stray_char", {11'b0, interrupt}, 12'o0000);
      @(negedge clk);
      send_byte(8'h0D, 1'b1);
      repeat (4) @(negedge clk);
      iot_chk("t6.krs_0d", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0015, 1'b1);

      // Overrun: second character overwrites with the flag still set
      @(negedge clk);
      send_byte(8'h7E, 1'b1);
      repeat (4) @(negedge clk);
      iot_chk("t7.overrun", 12'o6034, F1, 12'o0000, 1'b0, 1'b0, 12'o0176, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
